lsu_bus: RTL and testbench
==========================

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max REQ cycles without mem_ready before abort (legal 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port cpu_rst  input  1  synchronous active-low reset.
REQ-004 SHALL have port d_bus_en  input  1  CPU data request, held high until d_bus_ready seen.
REQ-005 SHALL have port ram_we  input  1  request is store.
REQ-006 SHALL have port ram_re  input  1  request is load.
REQ-007 SHALL have port mem_op  input  3  funct3 width/sign code.
REQ-008 SHALL have port d_addr  input  32  byte address.
REQ-009 SHALL have port d_wdata  input  32  store data, LSB-justified.
REQ-010 SHALL have port d_rdata  output  32  formatted load data.
REQ-011 SHALL have port d_bus_ready  output  1  one-cycle completion pulse.
REQ-012 SHALL have port d_err  output  1  completion with error, valid only with d_bus_ready.
REQ-013 SHALL have port mem_valid  output  1  memory request.
REQ-014 SHALL have port mem_we  output  1  memory write.
REQ-015 SHALL have port mem_addr  output  32  word address, bits [1:0] always 00.
REQ-016 SHALL have port mem_wstrb  output  4  byte-lane write strobes.
REQ-017 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-018 SHALL have port mem_ready  input  1  memory accepts/completes request this cycle.
REQ-019 SHALL have port mem_rdata  input  32  word read data, valid with mem_ready.

Function
REQ-020 SHALL implement FSM IDLE, REQ, RESP; all outputs registered.
REQ-021 IDLE: d_bus_en=1 -> capture d_addr, d_wdata, mem_op, ram_we, ram_re; go REQ if legal access, else RESP.
REQ-022 Legal: mem_op 000/001/010 store or load; 100/101 load only; all others illegal -> RESP, d_err=1, no mem access.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> RESP, d_err=1, no mem access.
REQ-024 d_bus_en=1 with ram_we=ram_re=0 -> RESP, d_err=0, d_rdata=0, no mem access.
REQ-025 ram_we=ram_re=1 -> treated as store.
REQ-026 REQ: mem_valid=1, addresses/data stable; mem_ready=1 -> capture mem_rdata, drop mem_valid next cycle, go RESP.
REQ-027 REQ: 8-bit cycle counter cleared on entry; counter reaching TIMEOUT-1 without mem_ready -> drop mem_valid, RESP with d_err=1, d_rdata=0.
REQ-028 RESP: d_bus_ready=1 for exactly one cycle, then IDLE; d_bus_en sampled in IDLE only, so back-to-back requests with d_bus_en held high are distinct.
REQ-029 Minimum latency: request seen cycle 0, mem_valid cycle 1, mem_ready cycle 1 -> d_bus_ready cycle 2.
REQ-030 Store strobes: SB 1<<addr[1:0]; SH addr[1]=0 -> 0011, else 1100; SW 1111; loads 0000, mem_we=0.
REQ-031 Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
REQ-032 Load: LB/LBU select byte addr[1:0], LH/LHU halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-033 d_rdata and d_err SHALL be 0 outside RESP.

Reset
REQ-034 cpu_rst=0 at clock edge -> IDLE, counter 0, mem_valid, mem_we, d_bus_ready, d_err 0, mem_addr, mem_wstrb, mem_wdata, d_rdata 0.
REQ-035 Reset in REQ or RESP SHALL abort: no d_bus_ready pulse, mem_valid 0 from next cycle.
REQ-036 Reset SHALL override simultaneous d_bus_en or mem_ready.

Verification
REQ-037 LB addr 0x103, mem_rdata 0x80FF_1234, mem_ready same cycle as mem_valid -> mem_addr 0x100, d_rdata 0xFFFF_FF80, d_bus_ready 2 cycles after request.
REQ-038 SH addr 0x22, d_wdata 0x0000_BEEF -> mem_we=1, mem_wstrb 1100, mem_wdata 0xBEEF_BEEF, mem_addr 0x20.
REQ-039 LW addr 0x06 -> no mem_valid, d_bus_ready and d_err 1 cycle after request, d_rdata 0.
REQ-040 TIMEOUT=4, mem_ready held 0 -> mem_valid high 4 cycles, then d_bus_ready=1, d_err=1.
REQ-041 Two LHU (0x42 then 0x40) with d_bus_en held high, mem_rdata 0xABCD_1234 -> d_rdata 0x0000_ABCD then 0x0000_1234, two separate single-cycle ready pulses.
REQ-042 cpu_rst=0 during REQ with mem_valid=1 -> mem_valid 0 next cycle, no d_bus_ready, new request after release served normally.

Source files
------------

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: one CPU data request at a time onto a
// word-addressed memory port, with lane steering, load formatting and timeout.
module lsu_bus #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        cpu_rst,
    input  logic        d_bus_en,
    input  logic        ram_we,
    input  logic        ram_re,
    input  logic [2:0]  mem_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_bus_ready,
    output logic        d_err,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [2:0]  op_q, op_n;
    logic [1:0]  off_q, off_n;
    logic        valid_n, we_n, ready_n, err_n;
    logic [31:0] addr_n, wdata_n, rdata_n;
    logic [3:0]  wstrb_n;

    logic        is_st, is_none, legal, aligned, go_mem;
    logic [3:0]  st_strb;
    logic [31:0] st_data, sh, ld_data;

    // Request decode straight from the CPU inputs, used only in IDLE
    always_comb begin
        is_none = !ram_we && !ram_re;
        is_st   = ram_we;
        case (mem_op)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !is_st;
            default:                legal = 1'b0;
        endcase
        case (mem_op[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !d_addr[0];
            2'b10:   aligned = (d_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        go_mem = !is_none && legal && aligned;
    end

    always_comb begin
        case (mem_op[1:0])
            2'b00: begin
                st_strb = 4'b0001 << d_addr[1:0];
                st_data = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                st_strb = d_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{d_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = d_wdata;
            end
        endcase
        if (!is_st) st_strb = 4'b0000;
    end

    always_comb begin
        sh = mem_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_data = {24'd0, sh[7:0]};
            3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ld_data = {16'd0, sh[15:0]};
            default: ld_data = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!cpu_rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            op_q        <= 3'd0;
            off_q       <= 2'd0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wstrb   <= 4'd0;
            mem_wdata   <= 32'd0;
            d_rdata     <= 32'd0;
            d_bus_ready <= 1'b0;
            d_err       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            op_q        <= op_n;
            off_q       <= off_n;
            mem_valid   <= valid_n;
            mem_we      <= we_n;
            mem_addr    <= addr_n;
            mem_wstrb   <= wstrb_n;
            mem_wdata   <= wdata_n;
            d_rdata     <= rdata_n;
            d_bus_ready <= ready_n;
            d_err       <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (d_bus_en) state_n = go_mem ? REQ : RESP;
            REQ:  if (mem_ready || cnt == LAST) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        cnt_n   = 8'd0;
        op_n    = op_q;
        off_n   = off_q;
        addr_n  = mem_addr;
        wstrb_n = mem_wstrb;
        wdata_n = mem_wdata;
        valid_n = 1'b0;
        we_n    = 1'b0;
        rdata_n = 32'd0;
        ready_n = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_bus_en) begin
                    op_n    = mem_op;
                    off_n   = d_addr[1:0];
                    addr_n  = {d_addr[31:2], 2'b00};
                    wstrb_n = st_strb;
                    wdata_n = st_data;
                    if (go_mem) begin
                        valid_n = 1'b1;
                        we_n    = is_st;
                    end else begin
                        ready_n = 1'b1;
                        err_n   = !is_none;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    ready_n = 1'b1;
                    rdata_n = mem_we ? 32'd0 : ld_data;
                end else if (cnt == LAST) begin
                    ready_n = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    valid_n = 1'b1;
                    we_n    = mem_we;
                    cnt_n   = cnt + 8'd1;
                end
            end
            RESP: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Randomized bench for lsu_bus against a transaction-level model of
// access legality, lane steering, load formatting and timeout latency.
module tb_lsu_bus;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        d_bus_en;
    logic        ram_we, ram_re;
    logic [2:0]  mem_op;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_bus_ready, d_err;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    lsu_bus #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .cpu_rst(cpu_rst),
        .d_bus_en(d_bus_en),
        .ram_we(ram_we),
        .ram_re(ram_re),
        .mem_op(mem_op),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_bus_ready(d_bus_ready),
        .d_err(d_err),
        .mem_valid(mem_valid),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; skew=1 when the DUT is still in its response cycle
    task automatic do_req(input logic we, input logic re,
                          input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int delay, input bit keep, input int skew);
        int nb, n, lat, exp_v, exp_lat;
        bit mem, err, tmo;
        logic [31:0] exp_rd, exp_wd, mask, v;
        logic [3:0] exp_strb;
        nb = 1 << op[1:0];
        mem = 0;
        err = 0;
        if (!we && !re) begin
        end else if (!(op inside {3'd0, 3'd1, 3'd2} ||
                       (op inside {3'd4, 3'd5} && !we))) begin
            err = 1;
        end else if (addr % nb != 0) begin
            err = 1;
        end else begin
            mem = 1;
        end
        tmo = mem && delay >= TO;
        if (tmo) err = 1;
        exp_v = !mem ? 0 : (tmo ? TO : delay + 1);
        exp_lat = exp_v + 1 + skew;
        mask = 32'((64'd1 << (8 * nb)) - 1);
        v = (rd >> (8 * addr[1:0])) & mask;
        if (!op[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        exp_rd = (mem && !tmo && !we) ? v : 32'd0;
        exp_strb = 4'((((1 << nb) - 1) << addr[1:0]));
        for (int i = 0; i < 4; i++)
            exp_wd[8 * i +: 8] = wd[8 * (i % nb) +: 8];

        d_bus_en = 1'b1;
        ram_we = we;
        ram_re = re;
        mem_op = op;
        d_addr = addr;
        d_wdata = wd;
        n = 0;
        lat = 0;
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (d_bus_ready) begin
                lat = t;
                break;
            end
            chk("quiet_out", {d_err, d_rdata[30:0]}, 32'd0);
            if (mem_valid) begin
                n++;
                if (n == 1) begin
                    chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    chk("mem_we", mem_we, we);
                    chk("mem_wstrb", mem_wstrb, we ? exp_strb : 4'd0);
                    if (we) chk("mem_wdata", mem_wdata, exp_wd);
                end
                mem_ready = (n - 1 == delay);
                mem_rdata = (n - 1 == delay) ? rd : $urandom;
            end else begin
                mem_ready = 1'b0;
            end
        end
        mem_ready = 1'b0;
        chk("latency", lat, exp_lat);
        chk("valid_cycles", n, exp_v);
        chk("valid_in_resp", mem_valid, 0);
        chk("d_err", d_err, err);
        chk("d_rdata", d_rdata, exp_rd);
        if (!keep) begin
            d_bus_en = 1'b0;
            @(negedge clk);
            chk("one_pulse", d_bus_ready, 0);
            chk("rdata_after", d_rdata, 0);
        end
    endtask

    initial begin
        bit keep, prev;
        logic [2:0] op;
        logic [31:0] a;
        cpu_rst = 1'b0;
        d_bus_en = 1'b1;
        ram_we = 1'b0;
        ram_re = 1'b1;
        mem_op = 3'd2;
        d_addr = 32'h10;
        d_wdata = 32'h0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_valid", mem_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_ready", d_bus_ready, 0);
        chk("rst_err", d_err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", d_rdata, 0);
        d_bus_en = 1'b0;
        mem_ready = 1'b0;
        cpu_rst = 1'b1;
        @(negedge clk);

        do_req(0, 1, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0);
        do_req(1, 0, 3'b001, 32'h22, 32'h0000_BEEF, 0, 1, 0, 0);
        do_req(0, 1, 3'b010, 32'h06, 0, 32'h1234_5678, 0, 0, 0);
        do_req(0, 1, 3'b010, 32'h40, 0, 32'h1234_5678, 10, 0, 0);
        do_req(0, 0, 3'b010, 32'h44, 0, 32'h1234_5678, 0, 0, 0);
        do_req(1, 1, 3'b100, 32'h44, 0, 0, 0, 0, 0);
        do_req(1, 1, 3'b000, 32'h45, 32'h77, 0, TO - 1, 0, 0);
        do_req(0, 1, 3'b101, 32'h42, 0, 32'hABCD_1234, 0, 1, 0);
        do_req(0, 1, 3'b101, 32'h40, 0, 32'hABCD_1234, 0, 0, 1);

        // Reset while a load is stalled in the request phase
        d_bus_en = 1'b1;
        ram_we = 1'b0;
        ram_re = 1'b1;
        mem_op = 3'b010;
        d_addr = 32'h80;
        repeat (3) @(negedge clk);
        chk("mid_valid", mem_valid, 1);
        d_bus_en = 1'b0;
        mem_ready = 1'b1;
        cpu_rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", mem_valid, 0);
        chk("abort_ready", d_bus_ready, 0);
        cpu_rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("abort_ready2", d_bus_ready, 0);
        do_req(0, 1, 3'b010, 32'h84, 0, 32'hCAFE_F00D, 1, 0, 0);

        prev = 0;
        for (int k = 0; k < 300; k++) begin
            op = ($urandom % 4 == 0) ? 3'($urandom) :
                 3'(($urandom % 5 < 3) ? $urandom % 3 : 4 + $urandom % 2);
            a = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            keep = (k != 299) && ($urandom % 3 == 0);
            do_req(1'($urandom), 1'($urandom), op, a, $urandom, $urandom,
                   $urandom % 6, keep, prev ? 1 : 0);
            prev = keep;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
